// File: rtl/shift_load_sequencer_pkg.sv
// Shared types and defaults for the shift-load sequencer.
// Optional feature macro: SHIFT_PARITY_EN (adds the PARITY state).
package shift_seq_pkg;

    localparam int unsigned DEF_WIDTH     = 4;
    localparam int unsigned DEF_SHIFT_LEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
`ifdef SHIFT_PARITY_EN
        PARITY,
`endif
        DONE
    } state_e;

endpackage

// File: rtl/shift_load_sequencer_if.sv
// Command and shift-register bus for the shift-load sequencer.
// master = command source / register side, slave = sequencer.
interface shift_load_sequencer_if
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned SHIFT_LEN = DEF_SHIFT_LEN
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SHIFT_LEN-1:0] in_tail;
    logic                 abort;
    logic                 load;
    logic [WIDTH-1:0]     data;
    logic                 din;
    logic                 busy;
    logic                 done;

    modport master (
        output in_valid, in_data, in_tail, abort,
        input  in_ready, load, data, din, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_tail, abort,
        output in_ready, load, data, din, busy, done
    );

endinterface

// File: rtl/shift_load_sequencer_serializer.sv
// Tail shift register plus emitted-bit counter.
// bit_out is the next tail bit to send (MSB-first); last is set once all
// SHIFT_LEN bits have been stepped out.
module shift_seq_serializer #(
    parameter int unsigned SHIFT_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_en,
    input  logic [SHIFT_LEN-1:0] tail_in,
    input  logic                 step_en,
    output logic                 bit_out,
    output logic                 last
);

    localparam int unsigned CNT_W = $clog2(SHIFT_LEN + 1);

    logic [SHIFT_LEN-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Load a fresh tail on accept, otherwise shift one bit per step
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load_en) begin
            sh_d  = tail_in;
            cnt_d = '0;
        end else if (step_en) begin
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Tail and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_out = sh_q[SHIFT_LEN-1];
    assign last    = (cnt_q == CNT_W'(SHIFT_LEN));

endmodule

// File: rtl/shift_load_sequencer.sv
// Upstream driver for the 4-bit loadable serial shift register.
// Accepts preload word + serial tail, pulses load, streams the tail
// MSB-first on din, then pulses done.
// Optional feature macro: SHIFT_PARITY_EN (even-parity bit after the tail).
module shift_load_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned SHIFT_LEN = DEF_SHIFT_LEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    shift_load_sequencer_if.slave  bus
);

    state_e           state_q, state_d;
    logic             accept, step, last, bit_out;
    logic             load_q, load_d;
    logic             din_q, din_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] data_q, data_d;
`ifdef SHIFT_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bus.in_ready = rst_n && (state_q == IDLE) && !bus.abort;
    assign accept       = bus.in_valid && bus.in_ready;

    shift_seq_serializer #(
        .SHIFT_LEN (SHIFT_LEN)
    ) u_serializer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (accept),
        .tail_in (bus.in_tail),
        .step_en (step),
        .bit_out (bit_out),
        .last    (last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort returns to IDLE from any active state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (accept) state_d = LOAD;
            LOAD:   state_d = bus.abort ? IDLE : SHIFT;
            SHIFT: begin
                if (bus.abort) state_d = IDLE;
`ifdef SHIFT_PARITY_EN
                else if (last) state_d = PARITY;
`else
                else if (last) state_d = DONE;
`endif
            end
`ifdef SHIFT_PARITY_EN
            PARITY: state_d = bus.abort ? IDLE : DONE;
`endif
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_comb begin
        load_d = (state_d == LOAD);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        step   = (state_d == SHIFT);
        din_d  = 1'b0;
        if (state_d == SHIFT) din_d = bit_out;
`ifdef SHIFT_PARITY_EN
        if (state_d == PARITY) din_d = par_q;
        par_d = accept ? ^bus.in_tail : par_q;
`endif
        data_d = accept ? bus.in_data : data_q;
    end

    // Output and latched-command registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q <= 1'b0;
            din_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            data_q <= '0;
`ifdef SHIFT_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            load_q <= load_d;
            din_q  <= din_d;
            done_q <= done_d;
            busy_q <= busy_d;
            data_q <= data_d;
`ifdef SHIFT_PARITY_EN
            par_q  <= par_d;
`endif
        end
    end

    assign bus.load = load_q;
    assign bus.data = data_q;
    assign bus.din  = din_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_shift_load_sequencer.sv
// Scoreboard bench for shift_load_sequencer (WIDTH=4, SHIFT_LEN=4).
// Honours SHIFT_PARITY_EN when defined for the build.
module tb_shift_load_sequencer;

    localparam int W  = 4;
    localparam int SL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    shift_load_sequencer_if #(.WIDTH(W), .SHIFT_LEN(SL)) bus ();

    shift_load_sequencer #(.WIDTH(W), .SHIFT_LEN(SL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic         load;
        logic [W-1:0] data;
        logic         din;
        logic         busy;
        logic         done;
        logic         rdy;
        logic         abrt;   // drive abort high after this cycle is checked
    } exp_t;

    exp_t          sb[$];
    logic [W-1:0]  cmd_d[$];
    logic [SL-1:0] cmd_t[$];

    int vectors     = 0;
    int miscompares = 0;

    function automatic void push_rec(input logic l, input logic [W-1:0] d,
                                     input logic di, input logic b,
                                     input logic dn, input logic r,
                                     input logic a);
        exp_t e;
        e.load = l; e.data = d; e.din = di; e.busy = b;
        e.done = dn; e.rdy = r; e.abrt = a;
        sb.push_back(e);
    endfunction

    // Expected cycle trace of one full command, ending with one IDLE cycle
    function automatic void push_cmd(input logic [W-1:0] d, input logic [SL-1:0] t);
        cmd_d.push_back(d);
        cmd_t.push_back(t);
        push_rec(1'b1, d, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = SL - 1; i >= 0; i--)
            push_rec(1'b0, d, t[i], 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SHIFT_PARITY_EN
        push_rec(1'b0, d, ^t, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        push_rec(1'b0, d, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_rec(1'b0, d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic present_next();
        if (cmd_d.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = cmd_d.pop_front();
            bus.in_tail  = cmd_t.pop_front();
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    // Pop up to n expected cycles, compare each on the falling edge
    task automatic drain(input string tag, input int n);
        exp_t          e;
        logic [W+4:0]  act, expv;
        int            k;
        k = 0;
        while (sb.size() > 0 && k < n) begin
            @(negedge clk);
            e    = sb.pop_front();
            act  = {bus.load, bus.data, bus.din, bus.busy, bus.done, bus.in_ready};
            expv = {e.load, e.data, e.din, e.busy, e.done, e.rdy};
            vectors++;
            if (act !== expv) begin
                miscompares++;
                $display("FAIL %s cycle %0d: {load,data,din,busy,done,in_ready} got %b expected %b",
                         tag, k, act, expv);
            end
            if (e.load) present_next();
            bus.abort = e.abrt;
            k++;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1111;
        bus.in_tail  = 4'b1111;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if ({bus.in_ready, bus.load, bus.din, bus.busy, bus.done, bus.data} !== '0) begin
                miscompares++;
                $display("FAIL reset_values: {in_ready,load,din,busy,done,data} got %b expected 0",
                         {bus.in_ready, bus.load, bus.din, bus.busy, bus.done, bus.data});
            end
        end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_release: {in_ready,busy} got %b expected 10",
                     {bus.in_ready, bus.busy});
        end
    endtask

    task automatic test_basic(input string tag);
        push_cmd(4'b1010, 4'b1101);
        present_next();
        drain(tag, 100);
    endtask

    task automatic test_back_to_back();
        push_cmd(4'b0011, 4'b0000);
        push_cmd(4'b1111, 4'b1111);
        present_next();
        drain("back_to_back", 100);
    endtask

    task automatic test_abort();
        cmd_d.push_back(4'b0110);
        cmd_t.push_back(4'b1001);
        push_rec(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push_rec(1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_rec(1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        // abort still high here, so in_ready stays low
        push_rec(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_rec(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_rec(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        present_next();
        drain("abort", 100);
    endtask

    task automatic test_mid_reset();
        push_cmd(4'b0101, 4'b0111);
        present_next();
        drain("mid_reset_pre", 3);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.load, bus.din, bus.busy, bus.done, bus.data} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_async: {in_ready,load,din,busy,done,data} got %b expected 0",
                     {bus.in_ready, bus.load, bus.din, bus.busy, bus.done, bus.data});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_tail  = '0;
        bus.abort    = 1'b0;
        test_reset();
        test_basic("basic");
        test_back_to_back();
        test_abort();
        test_mid_reset();
        test_basic("basic_after_reset");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
